// File: rtl/if_id_buffer_if.sv
// if_id_buffer_if: fetch-to-decode handshake bundle for the IF/ID buffer.
interface if_id_buffer_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        out_ready;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_pc_plus4
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_pc_plus4
    );
endinterface

// File: rtl/if_id_buffer.sv
// if_id_buffer: 2-entry FIFO between fetch and decode with flush and NOP-on-empty output.
module if_id_buffer #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic          clk,
    input logic          rst,
    if_id_buffer_if.slave bus
);
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] instr_q [2];
    logic [31:0] pc_q    [2];
    logic        push;
    logic        pop;

    // in_ready depends on registered count only, never on out_ready
    assign bus.in_ready     = count != 2'd2;
    assign bus.out_valid    = count != 2'd0;
    assign push             = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop              = bus.out_valid && bus.out_ready && !bus.flush;
    assign bus.out_instr    = bus.out_valid ? instr_q[rd_ptr] : NOP_INSTR;
    assign bus.out_pc       = bus.out_valid ? pc_q[rd_ptr] : 32'h0;
    assign bus.out_pc_plus4 = bus.out_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            count  <= count + {1'b0, push} - {1'b0, pop};
            rd_ptr <= rd_ptr ^ pop;
            wr_ptr <= wr_ptr ^ push;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= bus.in_instr;
            pc_q[wr_ptr]    <= bus.in_pc;
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed self-checking bench for if_id_buffer.
module tb_if_id_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    if_id_buffer_if bus ();

    if_id_buffer #(.NOP_INSTR(32'h0000_0013)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, "_ready"}, {31'b0, bus.in_ready}, 32'd1);
        chk({tag, "_instr"}, bus.out_instr, 32'h0000_0013);
        chk({tag, "_pc"}, bus.out_pc, 32'h0);
        chk({tag, "_pc4"}, bus.out_pc_plus4, 32'h4);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_instr"}, bus.out_instr, instr);
        chk({tag, "_pc"}, bus.out_pc, pc);
        chk({tag, "_pc4"}, bus.out_pc_plus4, pc + 32'd4);
    endtask

    initial begin
        drive(1'b1, 32'hDEAD_BEEF, 32'h40, 1'b1, 1'b1);
        cyc();
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_idle("reset");

        // streaming at count 1
        drive(1'b1, 32'hA000_000A, 32'h0, 1'b1, 1'b0);
        cyc();
        chk_head("strm_a", 32'hA000_000A, 32'h0);
        drive(1'b1, 32'hB000_000B, 32'h4, 1'b1, 1'b0);
        cyc();
        chk_head("strm_b", 32'hB000_000B, 32'h4);
        chk("strm_b_inrdy", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b1, 32'hC000_000C, 32'h8, 1'b1, 1'b0);
        cyc();
        chk_head("strm_c", 32'hC000_000C, 32'h8);
        chk("strm_c_inrdy", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc();
        chk("strm_drain", {31'b0, bus.out_valid}, 32'd0);

        // backpressure
        drive(1'b1, 32'hA111_1111, 32'h10, 1'b0, 1'b0);
        cyc();
        chk("bp_one_inrdy", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b1, 32'hB222_2222, 32'h14, 1'b0, 1'b0);
        cyc();
        chk("bp_full_inrdy", {31'b0, bus.in_ready}, 32'd0);
        chk_head("bp_full", 32'hA111_1111, 32'h10);
        drive(1'b1, 32'hC333_3333, 32'h18, 1'b0, 1'b0);
        cyc();
        chk_head("bp_hold", 32'hA111_1111, 32'h10);
        chk("bp_hold_inrdy", {31'b0, bus.in_ready}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("bp_no_comb_rdy", {31'b0, bus.in_ready}, 32'd0);
        cyc();
        chk_head("bp_pop_a", 32'hB222_2222, 32'h14);
        chk("bp_pop_inrdy", {31'b0, bus.in_ready}, 32'd1);
        cyc();
        chk("bp_c_absent", {31'b0, bus.out_valid}, 32'd0);

        // flush with count 2 and an incoming instruction
        drive(1'b1, 32'hE000_000E, 32'h20, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'hF000_000F, 32'h24, 1'b0, 1'b0);
        cyc();
        chk("fl_full", {31'b0, bus.in_ready}, 32'd0);
        drive(1'b1, 32'hD000_000D, 32'h28, 1'b1, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_idle("flush");
        drive(1'b1, 32'h6000_0006, 32'h30, 1'b0, 1'b0);
        cyc();
        chk_head("fl_next", 32'h6000_0006, 32'h30);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        chk_head("fl_stable", 32'h6000_0006, 32'h30);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc();
        chk("fl_alone", {31'b0, bus.out_valid}, 32'd0);

        // pc wrap and pointer wrap-around
        drive(1'b1, 32'h4800_0048, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cyc();
        chk_head("wrap_pc", 32'h4800_0048, 32'hFFFF_FFFC);
        chk("wrap_pc4", bus.out_pc_plus4, 32'h0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h9000_0000 + k, 32'h100 + 4 * k, 1'b1, 1'b0);
            cyc();
            chk_head($sformatf("wrap_%0d", k), 32'h9000_0000 + k, 32'h100 + 4 * k);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc();
        chk("wrap_drain", {31'b0, bus.out_valid}, 32'd0);

        // reset beats flush and push
        drive(1'b1, 32'h7000_0007, 32'h40, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h8000_0008, 32'h44, 1'b0, 1'b0);
        cyc();
        chk("rst_full", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        drive(1'b1, 32'h5000_0005, 32'h48, 1'b1, 1'b1);
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk_idle("midrst");
        cyc();
        chk("midrst_empty", {31'b0, bus.out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
